// File: rtl/fence_ctrl.sv
// fence_ctrl
//   Sequences the memory-ordering side effects of FENCE, FENCE.I and
//   SFENCE.VMA once one of them reaches commit port 0. The flow is: wait
//   for the store buffer to drain, then flush the D$ (FENCE, FENCE.I),
//   hold the I$ invalidate for a fixed number of cycles (FENCE.I only) or
//   pulse the TLB flush (SFENCE.VMA only), and finally pulse done together
//   with a pipeline flush so commit can retire the instruction.
//
// Parameters
//   ICACHE_FLUSH_CYCLES  cycles flush_icache_o stays high (legal 1..255)
//
// Ports
//   clk_i               core clock, rising edge
//   rst_ni              asynchronous active-low reset
//   fence_req_i         FENCE at commit port 0 (level)
//   fence_i_req_i       FENCE.I / dcache-flush request at commit port 0 (level)
//   sfence_vma_req_i    SFENCE.VMA at commit port 0 (level)
//   halt_i              blocks acceptance of a new sequence while idle
//   no_st_pending_i     store buffer is empty
//   flush_dcache_ack_i  D$ flush complete (single-cycle pulse)
//   flush_dcache_o      D$ flush request, held until acknowledged
//   flush_icache_o      I$ invalidate
//   flush_tlb_o         ITLB/DTLB flush pulse
//   flush_pipeline_o    front-end/issue flush pulse
//   done_o              sequence complete, commit may acknowledge port 0
//   busy_o              controller is not idle
module fence_ctrl #(
    parameter int unsigned ICACHE_FLUSH_CYCLES = 4
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic fence_req_i,
    input  logic fence_i_req_i,
    input  logic sfence_vma_req_i,
    input  logic halt_i,
    input  logic no_st_pending_i,
    input  logic flush_dcache_ack_i,
    output logic flush_dcache_o,
    output logic flush_icache_o,
    output logic flush_tlb_o,
    output logic flush_pipeline_o,
    output logic done_o,
    output logic busy_o
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_DRAIN  = 3'd1;
    localparam logic [2:0] S_DFLUSH = 3'd2;
    localparam logic [2:0] S_IFLUSH = 3'd3;
    localparam logic [2:0] S_TLB    = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;

    localparam logic [1:0] OP_NONE    = 2'd0;
    localparam logic [1:0] OP_FENCE   = 2'd1;
    localparam logic [1:0] OP_FENCE_I = 2'd2;
    localparam logic [1:0] OP_SFENCE  = 2'd3;

    // The counter counts down to zero, so it starts one below the cycle count.
    localparam logic [7:0] CNT_LOAD = 8'(ICACHE_FLUSH_CYCLES - 1);

    logic [2:0] state;
    logic [2:0] next_state;
    logic [1:0] op;
    logic [1:0] next_op;
    logic [7:0] cnt;
    logic [7:0] next_cnt;

    // Next-state logic. Requests are looked at only in IDLE; after that the
    // captured op alone steers the path, so the sequence finishes even if the
    // request lines drop or halt rises mid-flight.
    always_comb begin
        next_state = state;
        next_op    = op;
        next_cnt   = cnt;
        case (state)
            S_IDLE: begin
                if (!halt_i) begin
                    if (fence_i_req_i) begin
                        next_op    = OP_FENCE_I;
                        next_state = S_DRAIN;
                    end else if (fence_req_i) begin
                        next_op    = OP_FENCE;
                        next_state = S_DRAIN;
                    end else if (sfence_vma_req_i) begin
                        next_op    = OP_SFENCE;
                        next_state = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (no_st_pending_i) begin
                    next_state = (op == OP_SFENCE) ? S_TLB : S_DFLUSH;
                end
            end
            S_DFLUSH: begin
                if (flush_dcache_ack_i) begin
                    if (op == OP_FENCE_I) begin
                        next_state = S_IFLUSH;
                        next_cnt   = CNT_LOAD;
                    end else begin
                        next_state = S_DONE;
                    end
                end
            end
            S_IFLUSH: begin
                if (cnt == 8'd0) begin
                    next_state = S_DONE;
                end else begin
                    next_cnt = cnt - 8'd1;
                end
            end
            S_TLB: begin
                next_state = S_DONE;
            end
            S_DONE: begin
                next_state = S_IDLE;
                next_op    = OP_NONE;
            end
            default: begin
                next_state = S_IDLE;
                next_op    = OP_NONE;
                next_cnt   = 8'd0;
            end
        endcase
    end

    // State registers. Reset drops any sequence in progress, including an
    // outstanding D$ flush request; a late ack is then ignored in IDLE.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= S_IDLE;
            op    <= OP_NONE;
            cnt   <= 8'd0;
        end else begin
            state <= next_state;
            op    <= next_op;
            cnt   <= next_cnt;
        end
    end

    // Outputs are pure decodes of the state register, so no input reaches an
    // output within the same cycle.
    assign flush_dcache_o   = (state == S_DFLUSH);
    assign flush_icache_o   = (state == S_IFLUSH);
    assign flush_tlb_o      = (state == S_TLB);
    assign flush_pipeline_o = (state == S_DONE);
    assign done_o           = (state == S_DONE);
    assign busy_o           = (state != S_IDLE);

endmodule

// File: tb/tb_fence_ctrl.sv
// tb_fence_ctrl
//   Self-checking bench for fence_ctrl. Each sequence is described at the
//   transaction level (which request, how long halted, how long the store
//   buffer takes to drain, how long the D$ takes to ack) and expanded into
//   a per-cycle list of inputs and expected output vectors. The vector
//   order is {flush_dcache, flush_icache, flush_tlb, flush_pipeline, done,
//   busy}.
module tb_fence_ctrl;

    localparam int N = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic fence_req = 1'b0;
    logic fence_i_req = 1'b0;
    logic sfence_req = 1'b0;
    logic halt = 1'b0;
    logic no_st = 1'b0;
    logic ack = 1'b0;
    logic flush_dcache;
    logic flush_icache;
    logic flush_tlb;
    logic flush_pipeline;
    logic done;
    logic busy;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic fence;
        logic fence_i;
        logic sfence;
        logic halt;
        logic no_st;
        logic ack;
    } stim_t;

    stim_t      stim_q[$];
    logic [5:0] exp_q[$];
    string      tag_q[$];

    fence_ctrl #(.ICACHE_FLUSH_CYCLES(N)) dut (
        .clk_i              (clk),
        .rst_ni             (rst_n),
        .fence_req_i        (fence_req),
        .fence_i_req_i      (fence_i_req),
        .sfence_vma_req_i   (sfence_req),
        .halt_i             (halt),
        .no_st_pending_i    (no_st),
        .flush_dcache_ack_i (ack),
        .flush_dcache_o     (flush_dcache),
        .flush_icache_o     (flush_icache),
        .flush_tlb_o        (flush_tlb),
        .flush_pipeline_o   (flush_pipeline),
        .done_o             (done),
        .busy_o             (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [5:0] getOutputs();
        return {flush_dcache, flush_icache, flush_tlb, flush_pipeline, done, busy};
    endfunction

    task automatic checkOutput(input string tag, input logic [5:0] got, input logic [5:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("[TB] FAIL %s: got %b expected %b at %0t", tag, got, want, $time);
        end
    endtask

    task automatic driveInputs(input stim_t s);
        fence_req   = s.fence;
        fence_i_req = s.fence_i;
        sfence_req  = s.sfence;
        halt        = s.halt;
        no_st       = s.no_st;
        ack         = s.ack;
    endtask

    task automatic applyStimulus(input stim_t s);
        @(posedge clk);
        #1;
        driveInputs(s);
    endtask

    function automatic stim_t randomStim();
        return stim_t'(6'($urandom()));
    endfunction

    // mask is {fence_i, fence, sfence}
    function automatic stim_t withRequests(input stim_t s, input logic [2:0] mask);
        stim_t r;
        r         = s;
        r.fence_i = mask[2];
        r.fence   = mask[1];
        r.sfence  = mask[0];
        return r;
    endfunction

    task automatic pushCycle(input stim_t s, input logic [5:0] e, input string tag);
        stim_q.push_back(s);
        exp_q.push_back(e);
        tag_q.push_back(tag);
    endtask

    // Inputs while a sequence is in flight: everything random, with the
    // request lines either held (normal commit behaviour) or scrambled.
    function automatic stim_t bodyStim(input logic [2:0] mask, input bit scramble);
        stim_t s;
        s = randomStim();
        if (!scramble) s = withRequests(s, mask);
        return s;
    endfunction

    task automatic pushGap(input int n);
        for (int i = 0; i < n; i++) begin
            pushCycle(withRequests(randomStim(), 3'b000), 6'b000000, "idle_gap");
        end
    endtask

    // Expand one sequence into its cycle-by-cycle expectation.
    task automatic buildSequence(input logic [2:0] mask, input int h, input int d,
                                 input int a, input bit scramble);
        stim_t s;
        bit is_fence_i;
        bit is_sfence;
        is_fence_i = mask[2];
        is_sfence  = !mask[2] && !mask[1];
        for (int i = 0; i < h; i++) begin
            s      = withRequests(randomStim(), mask);
            s.halt = 1'b1;
            pushCycle(s, 6'b000000, "halted_idle");
        end
        s      = withRequests(randomStim(), mask);
        s.halt = 1'b0;
        pushCycle(s, 6'b000000, "capture");
        for (int i = 0; i <= d; i++) begin
            s       = bodyStim(mask, scramble);
            s.no_st = (i == d);
            pushCycle(s, 6'b000001, "drain");
        end
        if (!is_sfence) begin
            for (int i = 0; i <= a; i++) begin
                s     = bodyStim(mask, scramble);
                s.ack = (i == a);
                pushCycle(s, 6'b100001, "dflush");
            end
        end
        if (is_fence_i) begin
            for (int i = 0; i < N; i++) pushCycle(bodyStim(mask, scramble), 6'b010001, "iflush");
        end
        if (is_sfence) pushCycle(bodyStim(mask, scramble), 6'b001001, "tlb");
        pushCycle(bodyStim(mask, scramble), 6'b000111, "done");
    endtask

    // Play up to 'limit' queued cycles (negative means all), then discard the rest.
    task automatic playQueue(input int limit);
        stim_t s;
        logic [5:0] e;
        string t;
        int n;
        n = 0;
        while (stim_q.size() > 0 && (limit < 0 || n < limit)) begin
            s = stim_q.pop_front();
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            applyStimulus(s);
            @(negedge clk);
            checkOutput(t, getOutputs(), e);
            n++;
        end
        stim_q.delete();
        exp_q.delete();
        tag_q.delete();
    endtask

    initial begin
        stim_t s;

        // Reset state
        #1 rst_n = 1'b0;
        #1 checkOutput("reset_async_start", getOutputs(), 6'b000000);
        @(negedge clk);
        @(negedge clk);
        checkOutput("reset_state", getOutputs(), 6'b000000);
        rst_n = 1'b1;

        // Slow drain, delayed ack FENCE
        pushGap(1);
        buildSequence(3'b010, 0, 5, 3, 1'b0);
        playQueue(-1);

        // FENCE.I with immediate drain and ack
        buildSequence(3'b100, 0, 0, 0, 1'b0);
        playQueue(-1);

        // All three requests together take the FENCE.I path
        pushGap(1);
        buildSequence(3'b111, 0, 0, 0, 1'b0);
        playQueue(-1);

        // SFENCE.VMA held off by halt for three cycles
        pushGap(1);
        buildSequence(3'b001, 3, 0, 0, 1'b0);
        playQueue(-1);

        // Back-to-back FENCEs with spurious acks in idle/drain
        pushGap(2);
        buildSequence(3'b010, 0, 2, 1, 1'b0);
        buildSequence(3'b010, 0, 0, 0, 1'b0);
        playQueue(-1);

        // Reset in the middle of a D$ flush
        pushGap(1);
        buildSequence(3'b010, 0, 0, 6, 1'b0);
        playQueue(4);
        #2 rst_n = 1'b0;
        #1 checkOutput("reset_async_dflush", getOutputs(), 6'b000000);
        @(negedge clk);
        checkOutput("reset_held", getOutputs(), 6'b000000);
        #1;
        s       = withRequests(6'b000000, 3'b001);
        s.no_st = 1'b1;
        s.ack   = 1'b1;
        driveInputs(s);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("post_reset_accept", getOutputs(), 6'b000001);
        pushCycle(s, 6'b001001, "post_reset_tlb");
        pushCycle(s, 6'b000111, "post_reset_done");
        pushGap(1);
        playQueue(-1);

        // Randomised sequences
        for (int k = 0; k < 250; k++) begin
            pushGap($urandom_range(0, 2));
            buildSequence(3'($urandom_range(1, 7)), $urandom_range(0, 3), $urandom_range(0, 6),
                          $urandom_range(0, 6), 1'($urandom()));
            playQueue(-1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
